// File: rtl/aso_nvram_upload.sv
// Byte-wide save RAM shared by the game (port A) and the HPS ioctl path (port B).
// Serves HPS upload reads with ioctl_wait, accepts restore downloads, and requests uploads once dirty.
module aso_nvram_upload #(
  parameter int AW      = 10,
  parameter int IDX     = 4,
  parameter int HOLDOFF = 60
) (
  input  logic          i_clk,
  input  logic          RESETn,
  input  logic          ioctl_download,
  input  logic          ioctl_upload,
  input  logic [7:0]    ioctl_index,
  input  logic [24:0]   ioctl_addr,
  input  logic          ioctl_wr,
  input  logic          ioctl_rd,
  input  logic [7:0]    ioctl_dout,
  output logic [7:0]    ioctl_din,
  output logic          ioctl_wait,
  output logic          ioctl_upload_req,
  input  logic [AW-1:0] game_addr,
  input  logic          game_we,
  input  logic [7:0]    game_din,
  output logic [7:0]    game_dout,
  input  logic          game_vblank,
  output logic          game_busy
);

  localparam int         DEPTH  = 1 << AW;
  localparam logic [7:0] IDX_B  = 8'(IDX);
  localparam logic [7:0] HOLD_B = 8'(HOLDOFF);

  typedef enum logic [1:0] {IDLE, FETCH, LATCH, HOLD} state_t;

  state_t        state_q, state_d;
  logic          wait_q, wait_d;
  logic [7:0]    din_q, din_d;
  logic [24:0]   addr_q, addr_d;
  logic [7:0]    rd_b_q;
  logic [7:0]    game_dout_q;
  logic          busy_q;
  logic          dirty_q, dirty_d;
  logic          ul_q;
  logic          ul_wr_q, ul_wr_d;
  logic          vblank_q;
  logic [7:0]    cnt_q, cnt_d, cnt_inc;
  logic          req_q, req_d;

  logic [7:0]    mem [DEPTH];

  logic sel_dl, sel_ul, dl_wr_en, game_wr_en, ul_fall, vbl_rise;
  logic dl_addr_ok, ul_addr_ok;

  assign sel_dl     = ioctl_download & (ioctl_index == IDX_B);
  assign sel_ul     = ioctl_upload & (ioctl_index == IDX_B);
  assign dl_addr_ok = (ioctl_addr[24:AW] == '0);
  assign ul_addr_ok = (addr_q[24:AW] == '0);
  assign dl_wr_en   = ioctl_wr & sel_dl & dl_addr_ok;
  assign game_wr_en = game_we & ~busy_q;
  assign ul_fall    = ul_q & ~sel_ul;
  assign vbl_rise   = game_vblank & ~vblank_q;

  // Port B write is placed last so it wins a same-address collision with the game.
  always_ff @(posedge i_clk) begin
    if (game_wr_en) mem[game_addr] <= game_din;
    if (dl_wr_en) mem[ioctl_addr[AW-1:0]] <= ioctl_dout;
    rd_b_q <= mem[addr_q[AW-1:0]];
  end

  always_ff @(posedge i_clk) begin
    if (!RESETn) game_dout_q <= 8'h00;
    else         game_dout_q <= mem[game_addr];
  end

  // Upload read sequencer: wait covers the fetch, the latch and one hold cycle.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    din_d   = din_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: begin
        if (ioctl_rd & sel_ul) begin
          addr_d  = ioctl_addr;
          wait_d  = 1'b1;
          state_d = FETCH;
        end
      end
      FETCH: state_d = LATCH;
      LATCH: begin
        din_d   = ul_addr_ok ? rd_b_q : 8'hFF;
        state_d = HOLD;
      end
      HOLD: begin
        wait_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Dirty tracking and vblank-paced upload request.
  always_comb begin
    dirty_d = dirty_q;
    ul_wr_d = ul_wr_q;
    cnt_d   = cnt_q;
    req_d   = 1'b0;
    cnt_inc = (cnt_q >= HOLD_B) ? HOLD_B : cnt_q + 8'd1;
    if (sel_ul & ~ul_q) ul_wr_d = 1'b0;
    if (game_wr_en & (sel_ul | ul_q)) ul_wr_d = 1'b1;
    if (ul_fall & ~ul_wr_q) dirty_d = 1'b0;
    if (game_wr_en) dirty_d = 1'b1;
    if (vbl_rise) begin
      if (dirty_q && (cnt_inc >= HOLD_B) && !ioctl_upload && !ioctl_download) begin
        req_d = 1'b1;
        cnt_d = 8'd0;
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!RESETn) begin
      state_q  <= IDLE;
      wait_q   <= 1'b0;
      din_q    <= 8'h00;
      addr_q   <= '0;
      busy_q   <= 1'b0;
      dirty_q  <= 1'b0;
      ul_q     <= 1'b0;
      ul_wr_q  <= 1'b0;
      vblank_q <= 1'b0;
      cnt_q    <= 8'd0;
      req_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      din_q    <= din_d;
      addr_q   <= addr_d;
      busy_q   <= sel_dl;
      dirty_q  <= dirty_d;
      ul_q     <= sel_ul;
      ul_wr_q  <= ul_wr_d;
      vblank_q <= game_vblank;
      cnt_q    <= cnt_d;
      req_q    <= req_d;
    end
  end

  assign ioctl_din        = din_q;
  assign ioctl_wait       = wait_q;
  assign ioctl_upload_req = req_q;
  assign game_dout        = game_dout_q;
  assign game_busy        = busy_q;

endmodule

// File: tb/tb_aso_nvram_upload.sv
// Bench for aso_nvram_upload: directed vector table, hand sequences for multi-cycle cases,
// then randomized traffic against a behavioural RAM/dirty/holdoff model.
module tb_aso_nvram_upload;

  localparam int AW      = 10;
  localparam int IDX     = 4;
  localparam int HOLDOFF = 6;
  localparam int DEPTH   = 1 << AW;

  logic          i_clk = 1'b0;
  logic          RESETn = 1'b0;
  logic          ioctl_download = 1'b0;
  logic          ioctl_upload = 1'b0;
  logic [7:0]    ioctl_index = 8'd0;
  logic [24:0]   ioctl_addr = '0;
  logic          ioctl_wr = 1'b0;
  logic          ioctl_rd = 1'b0;
  logic [7:0]    ioctl_dout = 8'd0;
  logic [7:0]    ioctl_din;
  logic          ioctl_wait;
  logic          ioctl_upload_req;
  logic [AW-1:0] game_addr = '0;
  logic          game_we = 1'b0;
  logic [7:0]    game_din = 8'd0;
  logic [7:0]    game_dout;
  logic          game_vblank = 1'b0;
  logic          game_busy;

  aso_nvram_upload #(.AW(AW), .IDX(IDX), .HOLDOFF(HOLDOFF)) dut (
    .i_clk(i_clk), .RESETn(RESETn),
    .ioctl_download(ioctl_download), .ioctl_upload(ioctl_upload), .ioctl_index(ioctl_index),
    .ioctl_addr(ioctl_addr), .ioctl_wr(ioctl_wr), .ioctl_rd(ioctl_rd), .ioctl_dout(ioctl_dout),
    .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait), .ioctl_upload_req(ioctl_upload_req),
    .game_addr(game_addr), .game_we(game_we), .game_din(game_din), .game_dout(game_dout),
    .game_vblank(game_vblank), .game_busy(game_busy)
  );

  always #5 i_clk = ~i_clk;

  // Behavioural model
  logic [7:0] ram_m [DEPTH];
  bit dirty_m = 0;
  int edges_m = 0;
  bit ul_active_m = 0;
  bit ul_wrote_m = 0;
  int req_exp = 0;
  int req_seen = 0;

  int n_checks = 0;
  int n_pass = 0;

  typedef struct {
    logic [24:0] addr;
    logic [7:0]  exp;
  } vec_t;
  vec_t vecs[6];

  always @(negedge i_clk) if (ioctl_upload_req === 1'b1) req_seen++;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [7:0] ul_exp(input logic [24:0] a);
    return (a < 25'(DEPTH)) ? ram_m[a[AW-1:0]] : 8'hFF;
  endfunction

  task automatic do_reset();
    RESETn = 1'b0;
    tick();
    tick();
    RESETn = 1'b1;
    dirty_m = 0;
    edges_m = 0;
    tick();
  endtask

  task automatic game_write(input logic [AW-1:0] a, input logic [7:0] d, input bit busy);
    game_we = 1'b1;
    game_addr = a;
    game_din = d;
    tick();
    game_we = 1'b0;
    if (!busy) begin
      ram_m[a] = d;
      dirty_m = 1;
      if (ul_active_m) ul_wrote_m = 1;
    end
  endtask

  task automatic game_read(input logic [AW-1:0] a, input string nm);
    game_addr = a;
    tick();
    check(nm, 32'(game_dout), 32'(ram_m[a]));
  endtask

  task automatic dl_byte(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d);
    ioctl_download = 1'b1;
    ioctl_index = idx;
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr = 1'b1;
    tick();
    check("dl_no_wait", 32'(ioctl_wait), 32'd0);
    ioctl_wr = 1'b0;
    ioctl_download = 1'b0;
    tick();
    if (idx == 8'(IDX) && a < 25'(DEPTH)) ram_m[a[AW-1:0]] = d;
  endtask

  task automatic ul_begin();
    ioctl_upload = 1'b1;
    ioctl_index = 8'(IDX);
    tick();
    ul_active_m = 1;
    ul_wrote_m = 0;
  endtask

  task automatic ul_end();
    ioctl_upload = 1'b0;
    tick();
    ul_active_m = 0;
    if (!ul_wrote_m) dirty_m = 0;
  endtask

  // Strobe at cycle N, wait expected high N+1..N+3, data from N+3, wait low N+4.
  task automatic ul_read(input logic [24:0] a, input logic [7:0] exp);
    ioctl_rd = 1'b1;
    ioctl_addr = a;
    tick();
    ioctl_rd = 1'b0;
    check("wait_n1", 32'(ioctl_wait), 32'd1);
    tick();
    check("wait_n2", 32'(ioctl_wait), 32'd1);
    tick();
    check("wait_n3", 32'(ioctl_wait), 32'd1);
    check("din_n3", 32'(ioctl_din), 32'(exp));
    tick();
    check("wait_n4", 32'(ioctl_wait), 32'd0);
    check("din_hold", 32'(ioctl_din), 32'(exp));
  endtask

  task automatic vbl_edge();
    logic exp;
    exp = 1'b0;
    game_vblank = 1'b1;
    tick();
    edges_m = (edges_m + 1 > HOLDOFF) ? HOLDOFF : edges_m + 1;
    if (dirty_m && edges_m >= HOLDOFF && !ioctl_upload && !ioctl_download) begin
      exp = 1'b1;
      edges_m = 0;
      req_exp++;
    end
    check("req_on_vbl", 32'(ioctl_upload_req), 32'(exp));
    game_vblank = 1'b0;
    tick();
    check("req_one_cycle", 32'(ioctl_upload_req), 32'd0);
  endtask

  initial begin
    bit wait_seen;
    logic [7:0] d;
    logic [24:0] a;

    // Reset state
    do_reset();
    check("rst_din", 32'(ioctl_din), 32'd0);
    check("rst_wait", 32'(ioctl_wait), 32'd0);
    check("rst_req", 32'(ioctl_upload_req), 32'd0);
    check("rst_game_dout", 32'(game_dout), 32'd0);
    check("rst_busy", 32'(game_busy), 32'd0);

    // Restore download of the whole RAM, first four bytes fixed
    wait_seen = 0;
    ioctl_download = 1'b1;
    ioctl_index = 8'(IDX);
    for (int i = 0; i < DEPTH; i++) begin
      case (i)
        0: d = 8'h11;
        1: d = 8'h22;
        2: d = 8'h33;
        3: d = 8'h44;
        default: d = 8'($urandom_range(0, 255));
      endcase
      ioctl_wr = 1'b1;
      ioctl_addr = 25'(i);
      ioctl_dout = d;
      ram_m[i] = d;
      tick();
      if (ioctl_wait) wait_seen = 1;
    end
    ioctl_wr = 1'b0;
    ioctl_download = 1'b0;
    tick();
    check("dl_wait_never", 32'(wait_seen), 32'd0);
    check("dl_no_req", 32'(req_seen), 32'd0);
    game_read(0, "ram0_11");
    game_read(3, "ram3_44");
    check("ram3_const", 32'(game_dout), 32'h44);

    // Upload read vector table
    vecs[0] = '{addr: 25'd2,          exp: 8'h33};
    vecs[1] = '{addr: 25'd0,          exp: 8'h11};
    vecs[2] = '{addr: 25'(DEPTH),     exp: 8'hFF};
    vecs[3] = '{addr: 25'd3,          exp: 8'h44};
    vecs[4] = '{addr: 25'h1FFFFFF,    exp: 8'hFF};
    vecs[5] = '{addr: 25'd1,          exp: 8'h22};
    ul_begin();
    foreach (vecs[i]) ul_read(vecs[i].addr, vecs[i].exp);

    // Strobe during an active read is ignored
    ioctl_rd = 1'b1;
    ioctl_addr = 25'd0;
    tick();
    ioctl_addr = 25'd3;
    tick();
    ioctl_rd = 1'b0;
    tick();
    check("viol_din", 32'(ioctl_din), 32'h11);
    tick();
    check("viol_wait_low", 32'(ioctl_wait), 32'd0);
    check("viol_din_hold", 32'(ioctl_din), 32'h11);
    ul_end();

    // Read strobe without upload select
    ioctl_rd = 1'b1;
    ioctl_addr = 25'd1;
    tick();
    ioctl_rd = 1'b0;
    check("rd_unsel_wait", 32'(ioctl_wait), 32'd0);
    tick();
    check("rd_unsel_wait2", 32'(ioctl_wait), 32'd0);

    // Game write then HOLDOFF vblank edges: one request, then another after HOLDOFF more
    game_write(5, 8'hA5, 0);
    game_read(5, "game_dout_a5");
    check("game_dout_a5_const", 32'(game_dout), 32'hA5);
    for (int i = 0; i < 2 * HOLDOFF; i++) vbl_edge();
    check("req_count_t3", 32'(req_seen), 32'd2);

    // Clean upload clears dirty; game writes during IDX download are dropped
    ul_begin();
    ul_end();
    ioctl_download = 1'b1;
    ioctl_index = 8'(IDX);
    tick();
    check("busy_high", 32'(game_busy), 32'd1);
    game_write(7, 8'h5A, 1);
    ioctl_download = 1'b0;
    tick();
    check("busy_low", 32'(game_busy), 32'd0);
    game_read(7, "busy_write_dropped");
    for (int i = 0; i < HOLDOFF; i++) vbl_edge();
    dl_byte(8'd3, 25'd0, 8'h77);
    game_read(0, "wrong_idx_untouched");

    // Game write during upload keeps dirty; vblank during upload does not request
    ul_begin();
    ul_read(25'd2, 8'h33);
    game_write(9, 8'hC3, 0);
    vbl_edge();
    ul_end();
    vbl_edge();
    check("req_after_dirty_upload", 32'(req_seen), 32'd3);

    // Reset in the middle of a read, then retry
    ul_begin();
    ioctl_rd = 1'b1;
    ioctl_addr = 25'd2;
    tick();
    ioctl_rd = 1'b0;
    tick();
    RESETn = 1'b0;
    tick();
    check("rst_mid_wait", 32'(ioctl_wait), 32'd0);
    check("rst_mid_din", 32'(ioctl_din), 32'd0);
    RESETn = 1'b1;
    dirty_m = 0;
    edges_m = 0;
    ul_wrote_m = 0;
    tick();
    check("rst_mid_wait2", 32'(ioctl_wait), 32'd0);
    ul_read(25'd2, 8'h33);
    ul_end();
    game_read(5, "ram_kept_after_rst");

    // Randomized traffic against the model
    for (int it = 0; it < 400; it++) begin
      case ($urandom_range(0, 4))
        0: game_write(AW'($urandom_range(0, DEPTH - 1)), 8'($urandom_range(0, 255)), 0);
        1: game_read(AW'($urandom_range(0, DEPTH - 1)), "rnd_game_read");
        2: dl_byte(($urandom_range(0, 3) == 0) ? 8'd3 : 8'(IDX),
                   25'($urandom_range(0, 2 * DEPTH - 1)), 8'($urandom_range(0, 255)));
        3: begin
          ul_begin();
          a = 25'($urandom_range(0, DEPTH + 63));
          ul_read(a, ul_exp(a));
          if ($urandom_range(0, 1) == 1)
            game_write(AW'($urandom_range(0, DEPTH - 1)), 8'($urandom_range(0, 255)), 0);
          ul_end();
        end
        default: vbl_edge();
      endcase
    end

    tick();
    check("req_total", 32'(req_seen), 32'(req_exp));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
